// File: rtl/hazard_unit_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller:
// forward-select codes, scoreboard entry layout and the register-match rule.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memtoreg;
        logic [4:0] dst;
    } sb_entry_t;

    // A stage produces register r only if it is a live writer of a non-zero register.
    function automatic logic sb_match(input logic [4:0] r, input sb_entry_t s);
        return s.valid & s.regwrite & (s.dst != REG_ZERO) & (s.dst == r);
    endfunction

    // MEM wins over WB; a load in MEM has no ALU result to offer, so it falls through to WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input sb_entry_t m,
                                           input sb_entry_t w);
        if (sb_match(r, m) && !m.memtoreg) begin
            return FWD_MEM;
        end
        if (sb_match(r, w)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; holds at all-ones.
module sat_counter
    import hazard_unit_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: shadow EX/MEM/WB
// scoreboard, EX/ID forwarding selects, stall/flush control, counters and watchdog.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       dst_D,
    input  logic             uses_rs_D,
    input  logic             uses_rt_D,
    input  logic             regwrite_D,
    input  logic             memtoreg_D,
    input  logic             branch_D,
    input  logic             zero_D,
    output logic [1:0]       Forward_RSE,
    output logic [1:0]       Forward_RTE,
    output logic             Forward_RSD,
    output logic             Forward_RTD,
    output logic             C_L_DE_Rs,
    output logic             C_L_DE_Rt,
    output logic             C_B_D,
    output logic             if_branch,
    output logic             ID_EX_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hazard_err
);

    localparam int               RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    sb_entry_t        e_q, e_d;
    sb_entry_t        m_q, m_d;
    sb_entry_t        w_q, w_d;
    logic [4:0]       rs_e_q, rs_e_d;
    logic [4:0]       rt_e_q, rt_e_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             err_q, err_d;

    logic ld_rs;
    logic ld_rt;
    logic br_e;
    logic br_m;
    logic cbd;
    logic stall;
    logic err_set;
    logic flush;

    // Hazard detection from ID fields against the registered scoreboard
    always_comb begin
        ld_rs = uses_rs_D & sb_match(rs_D, e_q) & e_q.memtoreg;
        ld_rt = uses_rt_D & sb_match(rt_D, e_q) & e_q.memtoreg;
        br_e  = (uses_rs_D & sb_match(rs_D, e_q)) | (uses_rt_D & sb_match(rt_D, e_q));
        br_m  = (uses_rs_D & sb_match(rs_D, m_q) & m_q.memtoreg)
              | (uses_rt_D & sb_match(rt_D, m_q) & m_q.memtoreg);
        cbd   = branch_D & (br_e | br_m);
        stall = ld_rs | ld_rt | cbd;
        flush = branch_D & ~stall & zero_D;
    end

    // Next scoreboard state: a stalled ID instruction leaves a bubble behind in EX
    always_comb begin
        e_d    = '0;
        rs_e_d = REG_ZERO;
        rt_e_d = REG_ZERO;
        if (!stall) begin
            e_d.valid    = 1'b1;
            e_d.regwrite = regwrite_D;
            e_d.memtoreg = memtoreg_D;
            e_d.dst      = dst_D;
            rs_e_d       = rs_D;
            rt_e_d       = rt_D;
        end
        m_d = e_q;
        w_d = m_q;
    end

    // Watchdog: run_q is the number of stall cycles immediately preceding this one
    always_comb begin
        run_d   = '0;
        err_set = stall & (run_q >= RUN_MAX);
        err_d   = err_q | err_set;
        if (stall) begin
            run_d = (run_q < RUN_MAX) ? run_q + RUN_W'(1) : run_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            rs_e_q <= REG_ZERO;
            rt_e_q <= REG_ZERO;
            run_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            rs_e_q <= rs_e_d;
            rt_e_q <= rt_e_d;
            run_q  <= run_d;
            err_q  <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush),
        .cnt (flush_cnt)
    );

    assign Forward_RSE = fwd_sel(rs_e_q, m_q, w_q);
    assign Forward_RTE = fwd_sel(rt_e_q, m_q, w_q);
    assign Forward_RSD = branch_D & sb_match(rs_D, m_q) & ~m_q.memtoreg;
    assign Forward_RTD = branch_D & sb_match(rt_D, m_q) & ~m_q.memtoreg;
    assign C_L_DE_Rs   = ld_rs;
    assign C_L_DE_Rt   = ld_rt;
    assign C_B_D       = cbd;
    assign if_branch   = branch_D & ~stall;
    assign ID_EX_flush = stall;
    assign hazard_err  = err_q | err_set;

endmodule
